johnson_seq_monitor: RTL

//  Downstream consumer of the 6-state 4-bit counter code (0000,0001,0011,0111,1111,1110).

---
 rtl/jsm_pkg.sv | 33 +++
 rtl/jsm_decode.sv | 23 ++
 rtl/johnson_seq_monitor.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/jsm_pkg.sv
// Shared definitions for the 6-state Johnson-code sequence monitor.
package jsm_pkg;

  localparam int unsigned CODE_W  = 4;
  localparam int unsigned PHASE_W = 3;

  localparam logic [CODE_W-1:0] CODE_0 = 4'b0000;
  localparam logic [CODE_W-1:0] CODE_1 = 4'b0001;
  localparam logic [CODE_W-1:0] CODE_2 = 4'b0011;
  localparam logic [CODE_W-1:0] CODE_3 = 4'b0111;
  localparam logic [CODE_W-1:0] CODE_4 = 4'b1111;
  localparam logic [CODE_W-1:0] CODE_5 = 4'b1110;

  typedef logic [PHASE_W-1:0] phase_t;

  localparam phase_t PH_FIRST   = 3'd0;
  localparam phase_t PH_LAST    = 3'd5;
  localparam phase_t PH_ILLEGAL = 3'd7;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_t;

  // Mod-6 successor; an illegal phase has no successor.
  function automatic phase_t next_phase(input phase_t p);
    if (p < PH_LAST)       next_phase = p + PHASE_W'(1);
    else if (p == PH_LAST) next_phase = PH_FIRST;
    else                   next_phase = PH_ILLEGAL;
  endfunction

endpackage

// File: rtl/jsm_decode.sv
// Combinational Johnson code -> phase index lookup; unknown codes map to PH_ILLEGAL.
module jsm_decode
  import jsm_pkg::*;
(
  input  logic [3:0] code,
  output phase_t     phase
);

  // Table lookup of the six legal codes.
  always_comb begin
    phase = PH_ILLEGAL;
    case (code)
      CODE_0:  phase = 3'd0;
      CODE_1:  phase = 3'd1;
      CODE_2:  phase = 3'd2;
      CODE_3:  phase = 3'd3;
      CODE_4:  phase = 3'd4;
      CODE_5:  phase = 3'd5;
      default: phase = PH_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/johnson_seq_monitor.sv
// Johnson sequence monitor: decodes the 6-state counter code, acquires lock,
// counts sequence errors (saturating) and full periods (wrapping).
// Optional feature macro: JSM_STICKY_ERR_EN adds err_clr / err_sticky.
module johnson_seq_monitor
  import jsm_pkg::*;
#(
  parameter int unsigned LOCK_CNT   = 3,
  parameter int unsigned MISS_MAX   = 2,
  parameter int unsigned ERR_W      = 8,
  parameter int unsigned WRAP_W     = 16,
  parameter int unsigned ALLOW_HOLD = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [3:0]        q_in,
`ifdef JSM_STICKY_ERR_EN
  input  logic              err_clr,
  output logic              err_sticky,
`endif
  output logic [2:0]        phase,
  output logic              locked,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_cnt,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_cnt
);

  localparam int unsigned RUN_W  = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
  localparam int unsigned MISS_W = (MISS_MAX < 2) ? 1 : $clog2(MISS_MAX + 1);

  state_t            state, state_nxt;
  phase_t            prev, prev_nxt;
  phase_t            phase_nxt;
  phase_t            dec;
  logic [RUN_W-1:0]  run, run_nxt;
  logic [MISS_W-1:0] miss, miss_nxt;
  logic [ERR_W-1:0]  err_cnt_nxt;
  logic [WRAP_W-1:0] wrap_cnt_nxt;
  logic              err_pulse_nxt;
  logic              wrap_pulse_nxt;
  logic              step_legal;
  logic              step_hold;

  jsm_decode u_decode (
    .code  (q_in),
    .phase (dec)
  );

  // Classify the current sample against the previous one.
  always_comb begin
    step_legal = (dec != PH_ILLEGAL) && (dec == next_phase(prev));
    step_hold  = (ALLOW_HOLD != 0) && (dec != PH_ILLEGAL) && (dec == prev);
  end

  // Next-state, counters and pulses; nothing moves unless en samples a code.
  always_comb begin
    state_nxt      = state;
    prev_nxt       = prev;
    phase_nxt      = phase_t'(phase);
    run_nxt        = run;
    miss_nxt       = miss;
    err_cnt_nxt    = err_cnt;
    wrap_cnt_nxt   = wrap_cnt;
    err_pulse_nxt  = 1'b0;
    wrap_pulse_nxt = 1'b0;
    if (en) begin
      prev_nxt  = dec;
      phase_nxt = dec;
      case (state)
        HUNT: begin
          if (dec != PH_ILLEGAL) begin
            state_nxt = ACQ;
            run_nxt   = '0;
          end
        end
        ACQ: begin
          if (step_legal) begin
            if (run == RUN_W'(LOCK_CNT - 1)) begin
              state_nxt = LOCKED;
              run_nxt   = '0;
              miss_nxt  = '0;
            end else begin
              run_nxt = run + RUN_W'(1);
            end
          end else if (!step_hold) begin
            run_nxt = '0;
            if (dec == PH_ILLEGAL) state_nxt = HUNT;
          end
        end
        LOCKED: begin
          if (step_legal) begin
            miss_nxt = '0;
            if (prev == PH_LAST) begin
              wrap_pulse_nxt = 1'b1;
              wrap_cnt_nxt   = wrap_cnt + WRAP_W'(1);
            end
          end else if (!step_hold) begin
            err_pulse_nxt = 1'b1;
            if (err_cnt != '1) err_cnt_nxt = err_cnt + ERR_W'(1);
            if (miss == MISS_W'(MISS_MAX - 1)) begin
              state_nxt = HUNT;
              miss_nxt  = '0;
            end else begin
              miss_nxt = miss + MISS_W'(1);
            end
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
`ifdef JSM_STICKY_ERR_EN
    // Software clear acts on any cycle and overrides a same-cycle increment.
    if (err_clr) err_cnt_nxt = '0;
`endif
  end

  // State and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= HUNT;
      prev       <= PH_ILLEGAL;
      phase      <= PH_ILLEGAL;
      run        <= '0;
      miss       <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      err_cnt    <= '0;
      wrap_pulse <= 1'b0;
      wrap_cnt   <= '0;
    end else begin
      state      <= state_nxt;
      prev       <= prev_nxt;
      phase      <= phase_nxt;
      run        <= run_nxt;
      miss       <= miss_nxt;
      locked     <= (state_nxt == LOCKED);
      err_pulse  <= err_pulse_nxt;
      err_cnt    <= err_cnt_nxt;
      wrap_pulse <= wrap_pulse_nxt;
      wrap_cnt   <= wrap_cnt_nxt;
    end
  end

`ifdef JSM_STICKY_ERR_EN
  // Sticky error flag; clear wins over a same-cycle error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err_sticky <= 1'b0;
    else if (err_clr) err_sticky <= 1'b0;
    else if (err_pulse_nxt) err_sticky <= 1'b1;
  end
`endif

endmodule
